// File: rtl/breathe_pwm_array.sv
// Multi-channel PWM LED engine: OFF / STEADY / BREATHE / BLINK with per-channel phase offset.
// Optional macro BREATHE_GAMMA_EN squares the breathing ramp for a perceptual gamma of ~2.
package breathe_pwm_pkg;
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;
endpackage

module breathe_pwm_lane
    import breathe_pwm_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter int IDX        = 0,
    parameter int PHASE_STEP = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mask,
    input  mode_e            mode,
    input  logic [PWM_W-1:0] level_s,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W:0]   phase,
    output logic             o
);
    localparam int PH_W = PWM_W + 1;
    localparam logic [PWM_W:0] OFFS = PH_W'(IDX * PHASE_STEP);

    logic [PWM_W:0]   ph;
    logic [PWM_W-1:0] tri_v;
    logic [PWM_W-1:0] lvl;
    logic             o_d, o_q;
`ifdef BREATHE_GAMMA_EN
    logic [2*PWM_W-1:0] prod;
`endif

    always_comb begin
        ph    = phase + OFFS;
        // Upper half of the phase runs the ramp back down.
        tri_v = ph[PWM_W] ? ~ph[PWM_W-1:0] : ph[PWM_W-1:0];
`ifdef BREATHE_GAMMA_EN
        prod  = {{PWM_W{1'b0}}, tri_v} * {{PWM_W{1'b0}}, tri_v};
`endif
        lvl   = '0;
        case (mode)
            MODE_OFF:     lvl = '0;
            MODE_STEADY:  lvl = level_s;
`ifdef BREATHE_GAMMA_EN
            MODE_BREATHE: lvl = PWM_W'(prod >> PWM_W);
`else
            MODE_BREATHE: lvl = tri_v;
`endif
            MODE_BLINK:   lvl = ph[PWM_W] ? '1 : '0;
            default:      lvl = '0;
        endcase
        o_d = en & mask & (lvl > cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_q <= 1'b0;
        else        o_q <= o_d;
    end

    assign o = o_q;
endmodule

module breathe_pwm_array
    import breathe_pwm_pkg::*;
#(
    parameter int CH         = 8,
    parameter int PWM_W      = 8,
    parameter int DIV        = 500000,
    parameter int PHASE_STEP = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [CH-1:0]    cfg_mask,
    input  logic [PWM_W-1:0] cfg_level,
    output logic             tick,
    output logic [CH-1:0]    o
);
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PS_W-1:0]  presc_d, presc_q;
    logic [PWM_W-1:0] cnt_d, cnt_q;
    logic [PWM_W:0]   phase_d, phase_q;
    mode_e            mode_d, mode_q;
    logic [CH-1:0]    mask_d, mask_q;
    logic [PWM_W-1:0] level_d, level_q;
    logic             xfer;

    always_comb begin
        tick      = (presc_q == PS_W'(DIV - 1));
        cfg_ready = &cnt_q;
        xfer      = cfg_valid & cfg_ready;
        presc_d   = tick ? '0 : presc_q + PS_W'(1);
        cnt_d     = cnt_q + PWM_W'(1);
        // Phase freezes while disabled so breathing resumes where it left off.
        phase_d   = (tick && en) ? phase_q + (PWM_W+1)'(1) : phase_q;
        mode_d    = xfer ? mode_e'(cfg_mode) : mode_q;
        mask_d    = xfer ? cfg_mask : mask_q;
        level_d   = xfer ? cfg_level : level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            mode_q  <= MODE_OFF;
            mask_q  <= '0;
            level_q <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            level_q <= level_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        breathe_pwm_lane #(
            .PWM_W      (PWM_W),
            .IDX        (i),
            .PHASE_STEP (PHASE_STEP)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .mask    (mask_q[i]),
            .mode    (mode_q),
            .level_s (level_q),
            .cnt     (cnt_q),
            .phase   (phase_q),
            .o       (o[i])
        );
    end
endmodule
